// File: rtl/xcvr_mm_arbiter.sv
// -----------------------------------------------------------------------------
// xcvr_mm_arbiter
//
// Shares one Avalon-MM agent (the transceiver MM bridge) between two hosts,
// s0 and s1. Burst count is fixed at 1 and at most one transaction is in
// flight at a time. When both hosts request together, the grant goes
// round-robin to the host that was not granted last.
//
// Handshake: a host presents a command by holding sN_read or sN_write high
// with address/data stable. The command is accepted in the single cycle where
// that host's sN_waitrequest is low. On the bridge side the same rule applies
// to m0_read/m0_write against m0_waitrequest. Read data is valid for exactly
// the cycle in which the matching *_readdatavalid is high; *_readdata is zero
// otherwise.
//
// Optional feature macro: XCVR_MM_ARBITER_TIMEOUT_EN
//   Defined   : read-response watchdog. After TIMEOUT_CYCLES response cycles
//               without m0_readdatavalid, the granted host receives
//               32'hDEAD_BEEF (low DATA_WIDTH bits) and timeout_err pulses.
//   Undefined : the arbiter waits for the response indefinitely and
//               timeout_err is tied low.
//
// Parameters
//   DATA_WIDTH     : width of all readdata/writedata ports
//   HDL_ADDR_WIDTH : width of all address ports
//   TIMEOUT_CYCLES : watchdog limit, 1..65535 (used only with the macro)
//
// Ports
//   clk, reset_n                 : clock, asynchronous active-low reset
//   sN_address/read/write/
//     writedata/byteenable       : host N command inputs (N = 0, 1)
//   sN_waitrequest               : host N stall (low only in its accept cycle)
//   sN_readdata/readdatavalid    : host N read response
//   m0_address/writedata/
//     byteenable/read/write      : bridge-side command outputs
//   m0_waitrequest,
//   m0_readdata/readdatavalid    : bridge-side stall and read response
//   timeout_err                  : one-cycle pulse on watchdog expiry
//   dbg_state                    : current FSM state (0 IDLE, 1 CMD, 2 RESP)
// -----------------------------------------------------------------------------
module xcvr_mm_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int HDL_ADDR_WIDTH = 13,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                      clk,
   input  logic                      reset_n,

   input  logic [HDL_ADDR_WIDTH-1:0] s0_address,
   input  logic                      s0_read,
   input  logic                      s0_write,
   input  logic [DATA_WIDTH-1:0]     s0_writedata,
   input  logic [3:0]                s0_byteenable,
   output logic                      s0_waitrequest,
   output logic [DATA_WIDTH-1:0]     s0_readdata,
   output logic                      s0_readdatavalid,

   input  logic [HDL_ADDR_WIDTH-1:0] s1_address,
   input  logic                      s1_read,
   input  logic                      s1_write,
   input  logic [DATA_WIDTH-1:0]     s1_writedata,
   input  logic [3:0]                s1_byteenable,
   output logic                      s1_waitrequest,
   output logic [DATA_WIDTH-1:0]     s1_readdata,
   output logic                      s1_readdatavalid,

   output logic [HDL_ADDR_WIDTH-1:0] m0_address,
   output logic [DATA_WIDTH-1:0]     m0_writedata,
   output logic [3:0]                m0_byteenable,
   output logic                      m0_read,
   output logic                      m0_write,
   input  logic                      m0_waitrequest,
   input  logic [DATA_WIDTH-1:0]     m0_readdata,
   input  logic                      m0_readdatavalid,

   output logic                      timeout_err,
   output logic [1:0]                dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // The grant register doubles as the round-robin last-grant pointer:
   // it keeps the last winner once the transaction is over.
   // 0 = s0, 1 = s1. Reset value s1 lets s0 win the first contention.
   logic grant;
   logic grant_nxt;

   logic req0;
   logic req1;

   // Granted host's command, muxed once and reused for m0_* and decisions.
   logic [HDL_ADDR_WIDTH-1:0] sel_address;
   logic [DATA_WIDTH-1:0]     sel_writedata;
   logic [3:0]                sel_byteenable;
   logic                      sel_read;
   logic                      sel_write;

   logic                      accept;
   logic                      resp_fire;
   logic [DATA_WIDTH-1:0]     resp_data;

   assign req0 = s0_read | s0_write;
   assign req1 = s1_read | s1_write;

   always_comb begin
      if (grant) begin
         sel_address    = s1_address;
         sel_writedata  = s1_writedata;
         sel_byteenable = s1_byteenable;
         sel_read       = s1_read;
         sel_write      = s1_write;
      end else begin
         sel_address    = s0_address;
         sel_writedata  = s0_writedata;
         sel_byteenable = s0_byteenable;
         sel_read       = s0_read;
         sel_write      = s0_write;
      end
   end

   // --------------------------------------------------------------------------
   // Read-response watchdog
   // --------------------------------------------------------------------------
`ifdef XCVR_MM_ARBITER_TIMEOUT_EN
   localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

   logic [15:0] wd_cnt;
   logic        wd_expired;
   logic        to_fire;

   // Held at zero outside RESP, so it is zero on the first RESP cycle and
   // counts the RESP cycles already spent. Saturates rather than wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt <= 16'd0;
      end else if (state != RESP) begin
         wd_cnt <= 16'd0;
      end else if (wd_cnt != 16'hFFFF) begin
         wd_cnt <= wd_cnt + 16'd1;
      end
   end

   assign wd_expired  = (wd_cnt == 16'(TIMEOUT_CYCLES));
   assign timeout_err = to_fire;
`else
   assign timeout_err = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         grant <= 1'b1;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      m0_read   = 1'b0;
      m0_write  = 1'b0;
      accept    = 1'b0;
      resp_fire = 1'b0;
      resp_data = '0;
`ifdef XCVR_MM_ARBITER_TIMEOUT_EN
      to_fire   = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = CMD;
               if (req0 && req1) begin
                  grant_nxt = ~grant;
               end else begin
                  grant_nxt = req1;
               end
            end
         end

         CMD: begin
            m0_read  = sel_read;
            m0_write = sel_write;
            if (!m0_waitrequest) begin
               // Command type is taken as presented in the accept cycle; a
               // host that dropped its request here simply completes nothing.
               accept    = 1'b1;
               state_nxt = sel_read ? RESP : IDLE;
            end
         end

         RESP: begin
            // Real data has priority over a watchdog expiry in the same cycle.
            if (m0_readdatavalid) begin
               resp_fire = 1'b1;
               resp_data = m0_readdata;
               state_nxt = IDLE;
            end
`ifdef XCVR_MM_ARBITER_TIMEOUT_EN
            else if (wd_expired) begin
               resp_fire = 1'b1;
               resp_data = TIMEOUT_DATA;
               to_fire   = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign m0_address     = sel_address;
   assign m0_writedata   = sel_writedata;
   assign m0_byteenable  = sel_byteenable;

   assign s0_waitrequest = !(accept && !grant);
   assign s1_waitrequest = !(accept &&  grant);

   assign s0_readdatavalid = resp_fire && !grant;
   assign s1_readdatavalid = resp_fire &&  grant;
   assign s0_readdata      = s0_readdatavalid ? resp_data : '0;
   assign s1_readdata      = s1_readdatavalid ? resp_data : '0;

   assign dbg_state = state;

   // --------------------------------------------------------------------------
   // Structural invariants
   // --------------------------------------------------------------------------
   a_one_accept : assert property (@(posedge clk) disable iff (!reset_n)
      !(!s0_waitrequest && !s1_waitrequest));

   a_one_resp : assert property (@(posedge clk) disable iff (!reset_n)
      !(s0_readdatavalid && s1_readdatavalid));

   a_cmd_only : assert property (@(posedge clk) disable iff (!reset_n)
      (state != CMD) |-> !(m0_read || m0_write));

   a_resp_only : assert property (@(posedge clk) disable iff (!reset_n)
      (s0_readdatavalid || s1_readdatavalid) |-> (state == RESP));

endmodule

// File: tb/tb_xcvr_mm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xcvr_mm_arbiter
//
// Bench for xcvr_mm_arbiter. A table of two-host transactions is applied in a
// loop with per-cycle command/stall checks; read responses are checked by a
// monitor against an expected queue filled when each read is accepted. Hand
// sequences cover reset, stray responses, reset during RESP and (when
// XCVR_MM_ARBITER_TIMEOUT_EN is defined) the watchdog.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xcvr_mm_arbiter;

   localparam int DW = 32;
   localparam int AW = 13;
   localparam int TO = 8;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic [AW-1:0] s0_address, s1_address, m0_address;
   logic          s0_read, s0_write, s1_read, s1_write;
   logic [DW-1:0] s0_writedata, s1_writedata, m0_writedata;
   logic [3:0]    s0_byteenable, s1_byteenable, m0_byteenable;
   logic          s0_waitrequest, s1_waitrequest;
   logic [DW-1:0] s0_readdata, s1_readdata;
   logic          s0_readdatavalid, s1_readdatavalid;
   logic          m0_read, m0_write, m0_waitrequest, m0_readdatavalid;
   logic [DW-1:0] m0_readdata;
   logic          timeout_err;
   logic [1:0]    dbg_state;

   xcvr_mm_arbiter #(
      .DATA_WIDTH     (DW),
      .HDL_ADDR_WIDTH (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .s0_address       (s0_address),
      .s0_read          (s0_read),
      .s0_write         (s0_write),
      .s0_writedata     (s0_writedata),
      .s0_byteenable    (s0_byteenable),
      .s0_waitrequest   (s0_waitrequest),
      .s0_readdata      (s0_readdata),
      .s0_readdatavalid (s0_readdatavalid),
      .s1_address       (s1_address),
      .s1_read          (s1_read),
      .s1_write         (s1_write),
      .s1_writedata     (s1_writedata),
      .s1_byteenable    (s1_byteenable),
      .s1_waitrequest   (s1_waitrequest),
      .s1_readdata      (s1_readdata),
      .s1_readdatavalid (s1_readdatavalid),
      .m0_address       (m0_address),
      .m0_writedata     (m0_writedata),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .timeout_err      (timeout_err),
      .dbg_state        (dbg_state)
   );

   // ---------------------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;
   logic [DW:0] exp_q[$];   // {host, readdata}

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   logic          mon_v;
   logic [DW-1:0] mon_d;
   logic [DW:0]   mon_e;

   always @(negedge clk) begin
      #2;
      for (int h = 0; h < 2; h++) begin
         mon_v = (h == 1) ? s1_readdatavalid : s0_readdatavalid;
         mon_d = (h == 1) ? s1_readdata : s0_readdata;
         if (mon_v) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rdv: host %0d got data 0x%0h, required no response at %0t",
                        h, mon_d, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("rdv_host", 64'(h), 64'(mon_e[DW]));
               check("rdv_data", 64'(mon_d), 64'(mon_e[DW-1:0]));
            end
         end else begin
            check("rdata_zero", 64'(mon_d), 64'd0);
         end
      end
   end

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic          r0, w0, r1, w1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      int            wait_n;
      int            lat;
      logic [DW-1:0] rdata;
      logic          exp_g;
      logic          exp_rd;
      logic [AW-1:0] exp_a;
      logic [DW-1:0] exp_d;
      logic [3:0]    exp_be;
   } vec_t;

   function automatic vec_t mk(input logic r0, w0, r1, w1,
                               input logic [AW-1:0] a0, a1,
                               input logic [DW-1:0] d0, d1,
                               input int wait_n, lat,
                               input logic [DW-1:0] rdata,
                               input logic eg, er,
                               input logic [AW-1:0] ea,
                               input logic [DW-1:0] ed,
                               input logic [3:0] eb);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1;
      v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.wait_n = wait_n; v.lat = lat; v.rdata = rdata;
      v.exp_g = eg; v.exp_rd = er; v.exp_a = ea; v.exp_d = ed; v.exp_be = eb;
      return v;
   endfunction

   // ---------------------------------------------------------------- drivers
   task automatic idle_inputs();
      s0_read = 1'b0; s0_write = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
      m0_waitrequest = 1'b1; m0_readdatavalid = 1'b0; m0_readdata = '0;
   endtask

   // One full transaction: IDLE cycle, CMD cycles (wait_n stalls then accept),
   // then for reads lat empty RESP cycles followed by the response.
   task automatic run(input vec_t v);
      logic gw, ow;
      @(negedge clk);
      s0_read = v.r0; s0_write = v.w0; s1_read = v.r1; s1_write = v.w1;
      s0_address = v.a0; s1_address = v.a1;
      s0_writedata = v.d0; s1_writedata = v.d1;
      s0_byteenable = 4'h5; s1_byteenable = 4'hA;
      m0_waitrequest = 1'b1; m0_readdatavalid = 1'b0; m0_readdata = '0;
      #1;
      check("idle_s0_wait", 64'(s0_waitrequest), 64'd1);
      check("idle_s1_wait", 64'(s1_waitrequest), 64'd1);
      check("idle_m0_rw", 64'({m0_read, m0_write}), 64'd0);

      for (int k = 0; k <= v.wait_n; k++) begin
         @(negedge clk);
         m0_waitrequest = (k < v.wait_n);
         #1;
         check("cmd_m0_read", 64'(m0_read), 64'(v.exp_rd));
         check("cmd_m0_write", 64'(m0_write), 64'(!v.exp_rd));
         check("cmd_m0_addr", 64'(m0_address), 64'(v.exp_a));
         check("cmd_m0_be", 64'(m0_byteenable), 64'(v.exp_be));
         if (!v.exp_rd) check("cmd_m0_wdata", 64'(m0_writedata), 64'(v.exp_d));
         gw = v.exp_g ? s1_waitrequest : s0_waitrequest;
         ow = v.exp_g ? s0_waitrequest : s1_waitrequest;
         check("cmd_grant_wait", 64'(gw), 64'(k < v.wait_n));
         check("cmd_other_wait", 64'(ow), 64'd1);
         if (k == v.wait_n && v.exp_rd) exp_q.push_back({v.exp_g, v.rdata});
      end

      @(negedge clk);
      s0_read = 1'b0; s0_write = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
      m0_waitrequest = 1'b1;
      if (!v.exp_rd) begin
         #1;
         check("wr_done_m0_rw", 64'({m0_read, m0_write}), 64'd0);
         check("wr_done_wait", 64'({s0_waitrequest, s1_waitrequest}), 64'h3);
      end else begin
         for (int j = 0; j <= v.lat; j++) begin
            if (j > 0) @(negedge clk);
            m0_readdatavalid = (j == v.lat);
            m0_readdata = (j == v.lat) ? v.rdata : 32'h0BAD_0BAD;
            #1;
            check("resp_m0_rw", 64'({m0_read, m0_write}), 64'd0);
            check("resp_wait", 64'({s0_waitrequest, s1_waitrequest}), 64'h3);
            check("resp_tmo", 64'(timeout_err), 64'd0);
         end
         #2;
         check("resp_seen", 64'(exp_q.size()), 64'd0);
      end
   endtask

   // ---------------------------------------------------------------- test
   vec_t vecs[10];
   vec_t rv;

   initial begin
      // s0 write; s1 read stalled 5 then answered 3 after accept while s0
      // write waits; four contended reads alternating; mixed/boundary cases.
      vecs[0] = mk(0,1,0,0, 'h010, 'h000, 32'h1234_5678, 0, 0,0, 0,
                   0,0, 'h010, 32'h1234_5678, 4'h5);
      vecs[1] = mk(0,1,1,0, 'h044, 'h100, 32'h5555_0000, 0, 5,2, 32'hCAFE_0001,
                   1,1, 'h100, 0, 4'hA);
      vecs[2] = mk(1,0,1,0, 'h020, 'h030, 0, 0, 0,0, 32'hA000_0000,
                   0,1, 'h020, 0, 4'h5);
      vecs[3] = mk(1,0,1,0, 'h020, 'h030, 0, 0, 0,0, 32'hA000_0001,
                   1,1, 'h030, 0, 4'hA);
      vecs[4] = mk(1,0,1,0, 'h020, 'h030, 0, 0, 0,1, 32'hA000_0002,
                   0,1, 'h020, 0, 4'h5);
      vecs[5] = mk(1,0,1,0, 'h020, 'h030, 0, 0, 1,0, 32'hA000_0003,
                   1,1, 'h030, 0, 4'hA);
      vecs[6] = mk(0,0,0,1, 'h000, 'h1FFF, 0, 32'hFFFF_FFFF, 0,0, 0,
                   1,0, 'h1FFF, 32'hFFFF_FFFF, 4'hA);
      vecs[7] = mk(1,0,0,1, 'h0AA, 'h0BB, 0, 32'h0BB0_0BB0, 1,1, 32'h0F0F_0F0F,
                   0,1, 'h0AA, 0, 4'h5);
      vecs[8] = mk(1,0,0,0, 'h123, 'h000, 0, 0, 2,4, 32'h8765_4321,
                   0,1, 'h123, 0, 4'h5);
      vecs[9] = mk(0,1,0,1, 'h011, 'h022, 32'h1111_1111, 32'h2222_2222, 0,0, 0,
                   1,0, 'h022, 32'h2222_2222, 4'hA);

      s0_address = '0; s1_address = '0; s0_writedata = '0; s1_writedata = '0;
      s0_byteenable = '0; s1_byteenable = '0;
      idle_inputs();

      // Reset holds everything quiet even with requests and a ready bridge.
      reset_n = 1'b0;
      s0_read = 1'b1; s1_write = 1'b1; m0_waitrequest = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_s0_wait", 64'(s0_waitrequest), 64'd1);
      check("rst_s1_wait", 64'(s1_waitrequest), 64'd1);
      check("rst_rdv", 64'({s0_readdatavalid, s1_readdatavalid}), 64'd0);
      check("rst_m0_rw", 64'({m0_read, m0_write}), 64'd0);
      check("rst_tmo", 64'(timeout_err), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      @(negedge clk);
      idle_inputs();
      reset_n = 1'b1;

      // Stray response while idle is never forwarded.
      @(negedge clk);
      m0_readdatavalid = 1'b1; m0_readdata = 32'h5757_5757;
      #1;
      check("stray_idle_rdv", 64'({s0_readdatavalid, s1_readdatavalid}), 64'd0);
      check("stray_idle_state", 64'(dbg_state), 64'd0);
      @(negedge clk);
      m0_readdatavalid = 1'b0;

      for (int i = 0; i < 10; i++) run(vecs[i]);

      // Stray response during CMD (stalled and accept cycle) is ignored.
      @(negedge clk);
      s0_read = 1'b1; s0_address = 'h055; m0_waitrequest = 1'b1;
      m0_readdatavalid = 1'b1; m0_readdata = 32'h5151_5151;
      @(negedge clk);
      #1;
      check("stray_cmd_rdv", 64'(s0_readdatavalid), 64'd0);
      check("stray_cmd_m0_read", 64'(m0_read), 64'd1);
      check("stray_cmd_wait", 64'(s0_waitrequest), 64'd1);
      @(negedge clk);
      m0_waitrequest = 1'b0;
      #1;
      check("stray_acc_rdv", 64'(s0_readdatavalid), 64'd0);
      check("stray_acc_wait", 64'(s0_waitrequest), 64'd0);
      @(negedge clk);
      s0_read = 1'b0; m0_waitrequest = 1'b1;
      exp_q.push_back({1'b0, 32'hC0DE_0055});
      m0_readdatavalid = 1'b1; m0_readdata = 32'hC0DE_0055;
      #3;
      check("stray_then_resp", 64'(exp_q.size()), 64'd0);

      // Reset asserted during RESP abandons the read; late data is dropped.
      @(negedge clk);
      idle_inputs();
      s0_read = 1'b1; s0_address = 'h077; m0_waitrequest = 1'b0;
      @(negedge clk);
      #1;
      check("rr_accept", 64'(s0_waitrequest), 64'd0);
      @(negedge clk);
      s0_read = 1'b0; m0_waitrequest = 1'b1;
      #1;
      check("rr_in_resp", 64'(dbg_state), 64'd2);
      reset_n = 1'b0;
      #1;
      check("rr_m0_read", 64'(m0_read), 64'd0);
      check("rr_wait", 64'({s0_waitrequest, s1_waitrequest}), 64'h3);
      check("rr_state", 64'(dbg_state), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m0_readdatavalid = 1'b1; m0_readdata = 32'hBAD0_0077;
      #1;
      check("rr_late_rdv", 64'({s0_readdatavalid, s1_readdatavalid}), 64'd0);
      run(mk(0,0,0,1, 'h000, 'h0C3, 0, 32'h0DD0_0DD0, 0,0, 0,
             1,0, 'h0C3, 32'h0DD0_0DD0, 4'hA));

      // Randomised single-host transactions.
      for (int i = 0; i < 16; i++) begin
         logic          h, rd;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         h  = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 1));
         a  = AW'($urandom_range(0, (1 << AW) - 1));
         d  = $urandom();
         rv = mk(!h && rd, !h && !rd, h && rd, h && !rd, a, a, d, d,
                 $urandom_range(0, 3), $urandom_range(0, 5), $urandom(),
                 h, rd, a, d, h ? 4'hA : 4'h5);
         run(rv);
      end

`ifdef XCVR_MM_ARBITER_TIMEOUT_EN
      // Unanswered read: TO quiet RESP cycles, then DEAD_BEEF with a pulse.
      @(negedge clk);
      idle_inputs();
      s0_read = 1'b1; s0_address = 'h099; m0_waitrequest = 1'b0;
      @(negedge clk);
      @(negedge clk);
      s0_read = 1'b0; m0_waitrequest = 1'b1;
      for (int j = 1; j <= TO; j++) begin
         if (j > 1) @(negedge clk);
         #1;
         check("wd_quiet_tmo", 64'(timeout_err), 64'd0);
         check("wd_quiet_rdv", 64'(s0_readdatavalid), 64'd0);
      end
      @(negedge clk);
      exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      #1;
      check("wd_expire_tmo", 64'(timeout_err), 64'd1);
      #2;
      check("wd_expire_seen", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      m0_readdatavalid = 1'b1; m0_readdata = 32'h1A7E_0099;
      #1;
      check("wd_late_tmo", 64'(timeout_err), 64'd0);
      check("wd_late_rdv", 64'(s0_readdatavalid), 64'd0);

      // Expiry and real data in the same cycle: data wins, no pulse.
      @(negedge clk);
      idle_inputs();
      s1_read = 1'b1; s1_address = 'h0EE; m0_waitrequest = 1'b0;
      @(negedge clk);
      @(negedge clk);
      s1_read = 1'b0; m0_waitrequest = 1'b1;
      repeat (TO - 1) @(negedge clk);
      @(negedge clk);
      exp_q.push_back({1'b1, 32'h600D_0001});
      m0_readdatavalid = 1'b1; m0_readdata = 32'h600D_0001;
      #1;
      check("wd_tie_tmo", 64'(timeout_err), 64'd0);
      #2;
      check("wd_tie_seen", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      idle_inputs();
`endif

      repeat (3) @(negedge clk);
      #3;
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
